// File: rtl/median_pkg.sv
// median_pkg: shared pixel and column types for the 7x7 median filter
// front-end and the downstream sorter stages.
package median_pkg;

  localparam int PIXEL_W = 8;
  localparam int KERNEL  = 7;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // Index 0 is the top (oldest) row of the column, index KERNEL-1 the current row.
  typedef pixel_t [KERNEL-1:0] column_t;

  // Address width for a buffer of the given depth; never narrower than 1 bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : median_pkg

// File: rtl/median_line_buffer.sv
// median_line_buffer: one image line of pixel storage with a single shared
// address. The read port is combinational, so a beat sees the word stored at
// addr before that same beat's write lands (read-before-write).
module median_line_buffer
  import median_pkg::*;
#(
  parameter  int DEPTH = 640,
  localparam int AW    = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pixel_t        wdata,
  output pixel_t        rdata
);

  pixel_t mem [DEPTH];

  // Store the incoming pixel on accepted beats.
  // NOTE: the storage array has no reset; stale contents are harmless because
  // the top level gates emission on the row counter, and leaving the array
  // unreset keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule : median_line_buffer

// File: rtl/median_column_gen7.sv
// median_column_gen7: raster-order pixel stream in, vertical 7-pixel column
// out, built from six cascaded line buffers sharing the column address.
//
// Build option: define MEDIAN_ZERO_PAD_EN to also emit columns for the first
// six rows of a frame, with the rows above the image forced to zero. Without
// it, columns are emitted only once six full lines are buffered.
module median_column_gen7
  import median_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic   clk,
  input  logic   rst,      // asynchronous, active low
  input  logic   done_i,   // pixel valid
  input  pixel_t data_i,
  output logic   done_o,   // column valid
  output pixel_t S1,
  output pixel_t S2,
  output pixel_t S3,
  output pixel_t S4,
  output pixel_t S5,
  output pixel_t S6,
  output pixel_t S7,
  output logic   eof_o
);

  localparam int NUM_LB = KERNEL - 1;
  localparam int CW     = addr_w(IMG_W);
  localparam int RW     = addr_w(IMG_H);

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(NUM_LB);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  pixel_t  lb_rd [NUM_LB];
  column_t col_d;
  column_t col_q;
  logic    emit;
  logic    last_px;

  // ---------------------------------------------------------------------
  // Line buffer cascade: LB1 takes the live pixel, each later buffer takes
  // the word its predecessor just read out, so LBk holds row r-k.
  // ---------------------------------------------------------------------
  for (genvar k = 0; k < NUM_LB; k++) begin : g_lb
    pixel_t lb_wr;

    if (k == 0) begin : g_head
      assign lb_wr = data_i;
    end else begin : g_tail
      assign lb_wr = lb_rd[k-1];
    end

    median_line_buffer #(
      .DEPTH (IMG_W)
    ) u_lb (
      .clk   (clk),
      .we    (done_i),
      .addr  (col),
      .wdata (lb_wr),
      .rdata (lb_rd[k])
    );
  end

  // Raster position of the pixel on data_i; advances only on accepted beats.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (done_i) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last_px = (row == ROW_LAST) && (col == COL_LAST);

  // Emission gate: without padding a column exists only once six lines of
  // the current frame sit in the buffers.
`ifdef MEDIAN_ZERO_PAD_EN
  assign emit = done_i;
`else
  assign emit = done_i && (row >= ROW_FIRST);
`endif

  // Assemble the column: current pixel at the bottom, deeper buffers above.
  // NOTE: every bit of col_d gets a value before any condition is evaluated,
  // so no path through this block can infer a latch.
  always_comb begin
    col_d         = '0;
    col_d[NUM_LB] = data_i;
    for (int i = 0; i < NUM_LB; i++) begin
      col_d[i] = lb_rd[NUM_LB-1-i];
`ifdef MEDIAN_ZERO_PAD_EN
      // Entry i is row r-(6-i); above the frame it is forced to zero by row
      // count, whatever the buffer happens to hold.
      if (row < RW'(NUM_LB - i)) begin
        col_d[i] = '0;
      end
`endif
    end
  end

  // Output registers: strobes pulse for one cycle per emitted column; the
  // column data holds its last emitted value between emissions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_o <= 1'b0;
      eof_o  <= 1'b0;
      col_q  <= '0;
    end else begin
      done_o <= emit;
      eof_o  <= emit && last_px;
      if (emit) begin
        col_q <= col_d;
      end
    end
  end

  assign S1 = col_q[0];
  assign S2 = col_q[1];
  assign S3 = col_q[2];
  assign S4 = col_q[3];
  assign S5 = col_q[4];
  assign S6 = col_q[5];
  assign S7 = col_q[6];

endmodule : median_column_gen7

// File: tb/tb_median_column_gen7.sv
// tb_median_column_gen7: directed checks of the column generator on an 8x10
// ramp image (continuous, stalled, back-to-back and reset mid-frame) plus a
// 2x7 minimum-size instance fed random pixels against a small frame model.
module tb_median_column_gen7;

  localparam int W  = 8;
  localparam int H  = 10;
  localparam int W2 = 2;
  localparam int H2 = 7;

`ifdef MEDIAN_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance (8x10)
  logic       done_i;
  logic [7:0] data_i;
  logic       done_o, eof_o;
  logic [7:0] s1, s2, s3, s4, s5, s6, s7;

  // Minimum-width instance (2x7)
  logic       done2_i;
  logic [7:0] data2_i;
  logic       done2_o, eof2_o;
  logic [7:0] t1, t2, t3, t4, t5, t6, t7;

  median_column_gen7 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .done_i(done_i), .data_i(data_i), .done_o(done_o),
    .S1(s1), .S2(s2), .S3(s3), .S4(s4), .S5(s5), .S6(s6), .S7(s7), .eof_o(eof_o)
  );

  median_column_gen7 #(.IMG_W(W2), .IMG_H(H2)) dut2 (
    .clk(clk), .rst(rst), .done_i(done2_i), .data_i(data2_i), .done_o(done2_o),
    .S1(t1), .S2(t2), .S3(t3), .S4(t4), .S5(t5), .S6(t6), .S7(t7), .eof_o(eof2_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] col_main();
    return 64'({s1, s2, s3, s4, s5, s6, s7});
  endfunction

  function automatic logic [63:0] col_min();
    return 64'({t1, t2, t3, t4, t5, t6, t7});
  endfunction

  // Ramp pixel value at (r,c); rows above the frame read as zero.
  function automatic logic [7:0] ramp_px(input int base, input int r, input int c);
    if (r < 0) return 8'h00;
    return 8'((base + r * W + c) & 255);
  endfunction

  // Expected column for the ramp beat at (r,c): S1 is row r-6 ... S7 row r.
  function automatic logic [63:0] ramp_col(input int base, input int r, input int c);
    logic [55:0] v = '0;
    for (int k = 1; k <= 7; k++) begin
      v = {v[47:0], ramp_px(base, r - (7 - k), c)};
    end
    return 64'(v);
  endfunction

  logic [63:0] exp_last;

  // One accepted pixel on the main instance, checked one cycle later.
  task automatic beat(input int base, input int r, input int c, inout int ncol);
    bit emit;
    @(negedge clk);
    done_i = 1'b1;
    data_i = ramp_px(base, r, c);
    @(posedge clk);
    #1;
    emit = PAD || (r >= 6);
    check("done_o", 64'(done_o), 64'(emit));
    if (emit) begin
      exp_last = ramp_col(base, r, c);
      ncol++;
      check("eof_o", 64'(eof_o), 64'((r == H - 1) && (c == W - 1)));
    end
    check("column", col_main(), exp_last);
    done_i = 1'b0;
  endtask

  // One stall cycle: nothing accepted, nothing emitted, outputs hold.
  task automatic stall();
    @(negedge clk);
    done_i = 1'b0;
    data_i = 8'hAA;
    @(posedge clk);
    #1;
    check("stall done_o", 64'(done_o), 64'd0);
    check("stall hold", col_main(), exp_last);
  endtask

  task automatic frame(input int base, input bit stalls);
    int ncol = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        beat(base, r, c, ncol);
        if (!PAD && r == 6 && c == 0 && base == 0)
          check("first column", col_main(), 64'h0000_0008_1018_2028_30);
        if (PAD && r == 0 && c == 0)
          check("pad first column", col_main(), 64'd0);
        if (PAD && r == 2 && c == 3)
          check("pad (2,3)", col_main(), 64'h0000_0000_0003_0B13);
        if (r == H - 1 && c == W - 1)
          check("eof S7", 64'(s7), 64'((base + 79) & 255));
        if (stalls) stall();
      end
    end
    check("columns per frame", 64'(ncol), PAD ? 64'(W * H) : 64'((H - 6) * W));
  endtask

  // Minimum-width instance: random pixels, random stalls, frame model.
  logic [7:0] pix2 [H2][W2];

  task automatic min_frames(input int nframes);
    for (int f = 0; f < nframes; f++) begin
      int ncol = 0;
      for (int r = 0; r < H2; r++) begin
        for (int c = 0; c < W2; c++) begin
          logic [55:0] v;
          bit emit;
          if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            done2_i = 1'b0;
            data2_i = 8'($urandom);
            @(posedge clk);
            #1;
            check("min stall done_o", 64'(done2_o), 64'd0);
          end
          @(negedge clk);
          done2_i    = 1'b1;
          data2_i    = 8'($urandom);
          pix2[r][c] = data2_i;
          @(posedge clk);
          #1;
          done2_i = 1'b0;
          emit = PAD || (r >= 6);
          check("min done_o", 64'(done2_o), 64'(emit));
          if (emit) begin
            ncol++;
            v = '0;
            for (int k = 1; k <= 7; k++) begin
              int rr = r - (7 - k);
              v = {v[47:0], (rr < 0) ? 8'h00 : pix2[rr][c]};
            end
            check("min column", col_min(), 64'(v));
            check("min eof_o", 64'(eof2_o), 64'((r == H2 - 1) && (c == W2 - 1)));
          end
        end
      end
      check("min columns per frame", 64'(ncol), PAD ? 64'(W2 * H2) : 64'((H2 - 6) * W2));
    end
  endtask

  initial begin
    int ncol = 0;
    rst      = 1'b0;
    done_i   = 1'b0;
    data_i   = '0;
    done2_i  = 1'b0;
    data2_i  = '0;
    exp_last = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset done_o", 64'(done_o), 64'd0);
    check("reset eof_o", 64'(eof_o), 64'd0);
    check("reset column", col_main(), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Continuous ramp, then the same stream with stalls between beats.
    frame(0, 1'b0);
    frame(0, 1'b1);
    // Back-to-back frame right after the stalled one ends.
    frame(0, 1'b0);

    // Reset in the middle of row 7.
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == 7 && c == 3) break;
        beat(0, r, c, ncol);
      end
    end
    @(negedge clk);
    rst    = 1'b0;
    done_i = 1'b1;
    data_i = 8'h55;
    exp_last = '0;
    #1;
    check("async reset column", col_main(), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("in reset done_o", 64'(done_o), 64'd0);
      check("in reset column", col_main(), 64'd0);
    end
    @(negedge clk);
    rst    = 1'b1;
    done_i = 1'b0;
    frame(128, 1'b0);

    min_frames(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_median_column_gen7
